// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with registered sync, blank and wrap pulses.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic        frame_start,
  output logic        line_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          x_wrap;
  logic          y_wrap;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          blank_nxt;
  logic          ls_nxt;
  logic          fs_nxt;

  assign sync = 1'b0;

  // Next counter values; sync/blank decode from the next values keeps them aligned with DrawX/DrawY.
  always_comb begin
    x_nxt     = DrawX;
    y_nxt     = DrawY;
    x_wrap    = (DrawX == H_LAST);
    y_wrap    = (DrawY == V_LAST);
    ls_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    if (pix_ce) begin
      if (x_wrap) begin
        x_nxt  = '0;
        ls_nxt = 1'b1;
        if (y_wrap) begin
          y_nxt  = '0;
          fs_nxt = 1'b1;
        end else begin
          y_nxt = DrawY + CW'(1);
        end
      end else begin
        x_nxt = DrawX + CW'(1);
      end
    end
    hs_nxt    = !((x_nxt >= HS_BEG) && (x_nxt < HS_END));
    vs_nxt    = !((y_nxt >= VS_BEG) && (y_nxt < VS_END));
    blank_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      blank       <= blank_nxt;
      frame_start <= fs_nxt;
      line_start  <= ls_nxt;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Counts frame_start pulses; the edge following each pulse bumps the count.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a pixel-index reference model predicts every cycle for a small and a default-size generator.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hw; int hb;
    int va; int vf; int vw; int vb;
  } geom_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic        ls;
    logic [15:0] fc;
  } exp_t;

  localparam geom_t G_S = '{ha:16, hf:2, hw:4, hb:3, va:12, vf:2, vw:2, vb:3};
  localparam geom_t G_D = '{ha:640, hf:16, hw:96, hb:48, va:480, vf:10, vw:2, vb:33};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic pix_ce  = 1'b0;

  logic [9:0]  s_x, s_y, d_x, d_y;
  logic        s_hs, s_vs, s_blank, s_sync, s_fs, s_ls;
  logic        d_hs, d_vs, d_blank, d_sync, d_fs, d_ls;
  logic [15:0] s_fc, d_fc;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .sync(s_sync), .frame_start(s_fs), .line_start(s_ls)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen u_dflt (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .sync(d_sync), .frame_start(d_fs), .line_start(d_ls)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(d_fc)
`endif
  );

`ifndef VGA_FRAME_COUNT_EN
  assign s_fc = '0;
  assign d_fc = '0;
`endif

  exp_t q_s[$];
  exp_t q_d[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   cyc      = 0;
  bit   armed    = 0;

  int   p_s = 0, p_d = 0;
  bit   ls_s, fs_s, ls_d, fs_d;
  logic [15:0] fc_s = '0, fc_d = '0;

  function automatic int htot(geom_t g); return g.ha + g.hf + g.hw + g.hb; endfunction
  function automatic int vtot(geom_t g); return g.va + g.vf + g.vw + g.vb; endfunction

  // Expected outputs for raster position p, derived directly from the timing rules.
  function automatic exp_t expect_at(geom_t g, int p, bit ls, bit fs, logic [15:0] fc);
    int x;
    int y;
    exp_t e;
    x = p % htot(g);
    y = p / htot(g);
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= g.ha + g.hf && x < g.ha + g.hf + g.hw);
    e.vs    = !(y >= g.va + g.vf && y < g.va + g.vf + g.vw);
    e.blank = (x < g.ha) && (y < g.va);
    e.ls    = ls;
    e.fs    = fs;
    e.fc    = fc;
    return e;
  endfunction

  task automatic advance(input geom_t g, input bit rst, input bit ce,
                         inout int p, inout bit ls, inout bit fs, inout logic [15:0] fc);
    if (rst) begin
      p = 0; ls = 0; fs = 0; fc = '0;
    end else begin
      if (fs) fc = fc + 16'd1;
      if (ce) begin
        p  = (p + 1) % (htot(g) * vtot(g));
        ls = (p % htot(g)) == 0;
        fs = (p == 0);
      end else begin
        ls = 0; fs = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit ce);
    @(negedge vga_clk);
    reset  = rst;
    pix_ce = ce;
    @(posedge vga_clk);
    cyc++;
    if (rst) armed = 1;
    advance(G_S, rst, ce, p_s, ls_s, fs_s, fc_s);
    advance(G_D, rst, ce, p_d, ls_d, fs_d, fc_d);
    if (armed) begin
      q_s.push_back(expect_at(G_S, p_s, ls_s, fs_s, fc_s));
      q_d.push_back(expect_at(G_D, p_d, ls_d, fs_d, fc_d));
    end
  endtask

  task automatic check(input string nm, input exp_t a, input exp_t e, input logic sy);
    n_total++;
    if ({a.x, a.y, a.hs, a.vs, a.blank, a.fs, a.ls, sy} ===
        {e.x, e.y, e.hs, e.vs, e.blank, e.fs, e.ls, 1'b0}) begin
      n_passed++;
    end else begin
      $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b sync=%b want x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b ls=%b sync=0",
               nm, cyc, a.x, a.y, a.hs, a.vs, a.blank, a.fs, a.ls, sy,
               e.x, e.y, e.hs, e.vs, e.blank, e.fs, e.ls);
    end
`ifdef VGA_FRAME_COUNT_EN
    n_total++;
    if (a.fc === e.fc) n_passed++;
    else $display("FAIL %s_frame_cnt cyc=%0d got %0d want %0d", nm, cyc, a.fc, e.fc);
`endif
  endtask

  exp_t es, ed, as_, ad;

  // Monitor: outputs are sampled mid-cycle and compared against the queued predictions.
  always @(negedge vga_clk) begin
    if (q_s.size() > 0) begin
      es  = q_s.pop_front();
      as_ = '{x:s_x, y:s_y, hs:s_hs, vs:s_vs, blank:s_blank, fs:s_fs, ls:s_ls, fc:s_fc};
      check("small", as_, es, s_sync);
    end
    if (q_d.size() > 0) begin
      ed = q_d.pop_front();
      ad = '{x:d_x, y:d_y, hs:d_hs, vs:d_vs, blank:d_blank, fs:d_fs, ls:d_ls, fc:d_fc};
      check("dflt", ad, ed, d_sync);
    end
  end

  initial begin
    // Reset holds regardless of pix_ce.
    repeat (3) step(1, 0);
    repeat (2) step(1, 1);
    // One full default line plus wrap.
    repeat (800) step(0, 1);
    step(1, 0);
    // Three small frames free-running.
    repeat (3 * 475 + 7) step(0, 1);
    step(1, 1);
    // Alternating clock enable across two small frames.
    for (int i = 0; i < 1900; i++) step(0, (i % 2) == 0);
    // Reset while small generator is in hsync and vsync (x=20, y=15).
    step(1, 0);
    repeat (395) step(0, 1);
    step(1, 1);
    repeat (30) step(0, 1);
    // Random enables with rare resets.
    for (int i = 0; i < 8000; i++) step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0));
    step(0, 0);
    repeat (3) @(negedge vga_clk);
    n_total++;
    if (q_s.size() == 0 && q_d.size() == 0) n_passed++;
    else $display("FAIL drain got %0d/%0d pending want 0/0", q_s.size(), q_d.size());
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The parameter list SHALL be:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
REQ-002 The port list SHALL be, clock and reset first:
- vga_clk, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- pix_ce, in, 1, pixel clock-enable.
- DrawX, out, 10, current column.
- DrawY, out, 10, current line.
- hs, out, 1, horizontal sync, active-low.
- vs, out, 1, vertical sync, active-low.
- blank, out, 1, 1 = inside the visible region (drawing allowed), 0 = blanked.
- sync, out, 1, composite sync, tied 0.
- frame_start, out, 1, one-cycle pulse on frame wrap.
- line_start, out, 1, one-cycle pulse on line wrap.

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800), and V_TOTAL SHALL equal the corresponding vertical sum (525).
REQ-004 DrawX SHALL increment by 1 on each vga_clk edge where pix_ce=1.
REQ-005 DrawX SHALL wrap from H_TOTAL-1 to 0.
REQ-006 DrawY SHALL increment by 1 only on the edge where DrawX wraps.
REQ-007 DrawY SHALL wrap from V_TOTAL-1 to 0.
REQ-008 With pix_ce=0, all counters and level outputs SHALL hold, and frame_start and line_start SHALL be 0.
REQ-009 hs, vs and blank SHALL be registered and aligned with the DrawX/DrawY values of the same cycle, so combinational decode from the outputs is never needed downstream (zero relative latency).
REQ-010 hs SHALL be 0 exactly when H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-011 vs SHALL be 0 exactly when V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491), and 1 otherwise.
REQ-012 blank SHALL be 1 exactly when DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-013 line_start SHALL be 1 for the single pix_ce cycle in which DrawX has just become 0 via a wrap.
REQ-014 frame_start SHALL be 1 for the single pix_ce cycle in which (DrawX, DrawY) has just become (0,0) via a wrap; line_start SHALL also be 1 in that cycle.
REQ-015 Counter arithmetic SHALL be 10-bit unsigned; no value outside 0..H_TOTAL-1 or 0..V_TOTAL-1 SHALL ever appear.
REQ-016 sync SHALL be constant 0.

Reset
REQ-017 When reset=1 at a vga_clk edge, the outputs SHALL take: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, line_start=0, regardless of pix_ce.
REQ-018 Reset asserted mid-line or mid-frame SHALL take effect on the next edge.
REQ-019 The first pix_ce edge after reset release SHALL advance DrawX to 1.
REQ-020 No frame_start SHALL be generated for the post-reset (0,0); the first frame_start SHALL occur only after a full frame.

Configuration
REQ-021 With VGA_FRAME_COUNT_EN defined, the block SHALL add output frame_cnt (16 bits), which resets to 0, increments on each cycle where frame_start=1, and wraps 65535->0.
REQ-022 Without VGA_FRAME_COUNT_EN, the frame_cnt port and its logic SHALL be absent.
REQ-023 All other behaviour SHALL be identical with and without VGA_FRAME_COUNT_EN.

Verification
REQ-024 Reset, then pix_ce=1 for 800 edges -> DrawX runs 0..799 then 0, DrawY=1, line_start=1 exactly once, frame_start=0.
REQ-025 Free-run one full frame (420000 pix_ce edges) -> frame_start pulses once, at DrawX=0/DrawY=0; hs low for exactly 96 edges per line; vs low for exactly 1600 edges per frame.
REQ-026 Sweep a frame -> blank=1 for exactly 307200 edges; blank=0 at (640,0) and at (0,480); blank=1 at (639,479).
REQ-027 pix_ce toggling 1,0,1,0 -> counters advance every other edge; pulses never span a pix_ce=0 cycle; total frame period = 840000 edges.
REQ-028 Assert reset at (700,491) while hs=0 and vs=0 -> next edge shows DrawX=0, DrawY=0, hs=1, vs=1, blank=1.
REQ-029 With VGA_FRAME_COUNT_EN defined, run 3 frames -> frame_cnt=3; force the counter to 65535 and complete one frame -> frame_cnt=0.
